// File: rtl/lcd_pkg.sv
// Shared constants, instruction decode and DDRAM address helpers for the
// HD44780-style responder (lcd_responder, lcd_ddram).
package lcd_pkg;

  localparam int unsigned DDRAM_DEPTH = 80;
  localparam int unsigned LINE_LEN    = 40;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Lowest encoding of each instruction class
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNCSET = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  // Instruction classes (NOP covers the unassigned 0x00 encoding)
  localparam logic [3:0] CLS_NOP     = 4'd0;
  localparam logic [3:0] CLS_CLEAR   = 4'd1;
  localparam logic [3:0] CLS_HOME    = 4'd2;
  localparam logic [3:0] CLS_ENTRY   = 4'd3;
  localparam logic [3:0] CLS_DISPCTL = 4'd4;
  localparam logic [3:0] CLS_SHIFT   = 4'd5;
  localparam logic [3:0] CLS_FUNCSET = 4'd6;
  localparam logic [3:0] CLS_CGRAM   = 4'd7;
  localparam logic [3:0] CLS_DDRAM   = 4'd8;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_INIT_FILL  = 2'd0;
  localparam state_t ST_IDLE       = 2'd1;
  localparam state_t ST_EXEC       = 2'd2;
  localparam state_t ST_CLEAR_FILL = 2'd3;

  // Class of an instruction byte: the highest set bit selects it
  function automatic logic [3:0] instr_class(input logic [7:0] d);
    logic [3:0] c;
    c = CLS_NOP;
    if (d[7])      c = CLS_DDRAM;
    else if (d[6]) c = CLS_CGRAM;
    else if (d[5]) c = CLS_FUNCSET;
    else if (d[4]) c = CLS_SHIFT;
    else if (d[3]) c = CLS_DISPCTL;
    else if (d[2]) c = CLS_ENTRY;
    else if (d[1]) c = CLS_HOME;
    else if (d[0]) c = CLS_CLEAR;
    return c;
  endfunction

  // True for addresses inside either 40-byte line
  function automatic logic addr_valid(input logic [6:0] a);
    return a[5:0] < 6'(LINE_LEN);
  endfunction

  // DDRAM address to linear index 0..79
  function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
    return a[6] ? (7'(a[5:0]) + 7'(LINE_LEN)) : a;
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    logic [6:0] n;
    if (a == LINE1_LAST)      n = LINE2_BASE;
    else if (a == LINE2_LAST) n = LINE1_BASE;
    else                      n = a + 7'd1;
    return n;
  endfunction

  function automatic logic [6:0] prev_addr(input logic [6:0] a);
    logic [6:0] p;
    if (a == LINE1_BASE)      p = LINE2_LAST;
    else if (a == LINE2_BASE) p = LINE1_LAST;
    else                      p = a - 7'd1;
    return p;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one write port, two registered read ports.
// Reads of an index written in the same cycle return the old byte.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [6:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [6:0] a_idx,
  input  logic       a_valid,
  output logic [7:0] a_data,
  input  logic [6:0] b_idx,
  input  logic       b_valid,
  output logic [7:0] b_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered read ports; invalid addresses read as 0x00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= 8'h00;
      b_data <= 8'h00;
    end else begin
      a_data <= a_valid ? mem[a_idx] : 8'h00;
      b_data <= b_valid ? mem[b_idx] : 8'h00;
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style bus responder: decodes EN/RS/RW transactions, holds the
// 80-byte DDRAM, cursor and display flags, and models instruction busy time.
// Optional bus read-back is enabled by defining LCD_RESP_READ_EN.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_CYCLES   = 185,
  parameter int unsigned CLEAR_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       two_line,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_strobe,
  output logic       err
);

  localparam int unsigned CNT_MAX = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       fill_idx, fill_nxt;
  logic [6:0]       addr_nxt, step_addr;
  logic             display_nxt, cursor_nxt, blink_nxt, incr_nxt, two_line_nxt;
  logic             busy_nxt, strobe_nxt, err_nxt;
  logic [7:0]       data_out_nxt;
  logic             en_q, rs_q, rw_q;
  logic [7:0]       data_q;
  logic             commit;
  logic [3:0]       cls;
  logic             go_short, go_long, go_clear;
  logic             wr_en;
  logic [6:0]       wr_idx;
  logic [7:0]       wr_data;
  logic [7:0]       bus_rd_char;

  assign commit    = en_q & ~en;
  assign cls       = instr_class(data_q);
  assign step_addr = incr ? next_addr(cursor_addr) : prev_addr(cursor_addr);

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .a_idx   (addr_to_idx(rd_addr)),
    .a_valid (addr_valid(rd_addr)),
    .a_data  (rd_char),
    .b_idx   (addr_to_idx(cursor_addr)),
    .b_valid (1'b1),
    .b_data  (bus_rd_char)
  );

`ifndef LCD_RESP_READ_EN
  logic unused_bus_rd;
  assign unused_bus_rd = ^bus_rd_char;
`endif

  // Bus capture: hold the last values seen while en is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      en_q <= en;
      if (en) begin
        rs_q   <= rs;
        rw_q   <= rw;
        data_q <= data_in;
      end
    end
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT_FILL;
      cnt         <= '0;
      fill_idx    <= '0;
      busy        <= 1'b1;
      cursor_addr <= LINE1_BASE;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      incr        <= 1'b1;
      two_line    <= 1'b0;
      cmd_strobe  <= 1'b0;
      err         <= 1'b0;
      data_out    <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fill_idx    <= fill_nxt;
      busy        <= busy_nxt;
      cursor_addr <= addr_nxt;
      display_on  <= display_nxt;
      cursor_on   <= cursor_nxt;
      blink_on    <= blink_nxt;
      incr        <= incr_nxt;
      two_line    <= two_line_nxt;
      cmd_strobe  <= strobe_nxt;
      err         <= err_nxt;
      data_out    <= data_out_nxt;
    end
  end

  // Next-state, instruction decode and DDRAM write selection
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fill_nxt     = fill_idx;
    addr_nxt     = cursor_addr;
    display_nxt  = display_on;
    cursor_nxt   = cursor_on;
    blink_nxt    = blink_on;
    incr_nxt     = incr;
    two_line_nxt = two_line;
    err_nxt      = 1'b0;
    go_short     = 1'b0;
    go_long      = 1'b0;
    go_clear     = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = fill_idx;
    wr_data      = CHAR_SPACE;
    data_out_nxt = 8'h00;

    // Fill sweep and busy countdown
    case (state)
      ST_INIT_FILL, ST_CLEAR_FILL: begin
        wr_en    = 1'b1;
        fill_nxt = fill_idx + 7'd1;
        if (state == ST_CLEAR_FILL && cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        if (fill_idx == 7'(DDRAM_DEPTH - 1)) begin
          fill_nxt = '0;
          // Only a minimum-length clear can expire on the last fill cycle
          if (state == ST_INIT_FILL || cnt == '0) state_nxt = ST_IDLE;
          else                                    state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: ;
    endcase

    // Write-transaction commit
    if (commit && !rw_q) begin
      if (busy) begin
        err_nxt = 1'b1;
      end else if (rs_q) begin
        wr_en    = 1'b1;
        wr_idx   = addr_to_idx(cursor_addr);
        wr_data  = data_q;
        addr_nxt = step_addr;
        go_short = 1'b1;
      end else begin
        case (cls)
          CLS_CLEAR: begin
            addr_nxt = LINE1_BASE;
            incr_nxt = 1'b1;
            go_clear = 1'b1;
          end
          CLS_HOME: begin
            addr_nxt = LINE1_BASE;
            go_long  = 1'b1;
          end
          CLS_ENTRY: begin
            incr_nxt = data_q[1];
            go_short = 1'b1;
          end
          CLS_DISPCTL: begin
            display_nxt = data_q[2];
            cursor_nxt  = data_q[1];
            blink_nxt   = data_q[0];
            go_short    = 1'b1;
          end
          CLS_SHIFT: begin
            if (!data_q[3]) addr_nxt = data_q[2] ? next_addr(cursor_addr) : prev_addr(cursor_addr);
            go_short = 1'b1;
          end
          CLS_FUNCSET: begin
            two_line_nxt = data_q[3];
            go_short     = 1'b1;
          end
          CLS_CGRAM: err_nxt = 1'b1;
          CLS_DDRAM: begin
            if (addr_valid(data_q[6:0])) begin
              addr_nxt = data_q[6:0];
              go_short = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
          default: go_short = 1'b1;
        endcase
      end
    end

`ifdef LCD_RESP_READ_EN
    // Data read commit steps the cursor like a write
    if (commit && rw_q && rs_q) begin
      if (busy) begin
        err_nxt = 1'b1;
      end else begin
        addr_nxt = step_addr;
        go_short = 1'b1;
      end
    end
    data_out_nxt = data_out;
    if (en && rw) data_out_nxt = rs ? bus_rd_char : {busy, cursor_addr};
`endif

    if (go_clear) begin
      state_nxt = ST_CLEAR_FILL;
      cnt_nxt   = CNT_W'(CLEAR_CYCLES - 1);
      fill_nxt  = '0;
    end else if (go_long) begin
      state_nxt = ST_EXEC;
      cnt_nxt   = CNT_W'(CLEAR_CYCLES - 1);
    end else if (go_short) begin
      state_nxt = ST_EXEC;
      cnt_nxt   = CNT_W'(CMD_CYCLES - 1);
    end

    strobe_nxt = go_clear | go_long | go_short;
    busy_nxt   = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: stimulus queues expected pulses and
// probe results; a monitor pops and compares them as the DUT presents them.
module tb_lcd_responder;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] data_out, rd_char;
  logic       busy, display_on, cursor_on, blink_on, incr, two_line;
  logic       cmd_strobe, err;
  logic [6:0] cursor_addr;

  lcd_responder #(.CMD_CYCLES(185), .CLEAR_CYCLES(4000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rs(rs), .rw(rw), .data_in(data_in),
    .data_out(data_out), .busy(busy), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .incr(incr), .two_line(two_line), .rd_addr(rd_addr), .rd_char(rd_char),
    .cmd_strobe(cmd_strobe), .err(err)
  );

  always #5 clk = ~clk;

  localparam int K_CHAR = 0, K_ADDR = 1, K_FLAGS = 2, K_BUSY = 3, K_DOUT = 4, K_MEAS = 5;
  localparam logic [1:0] EV_NONE = 2'b00, EV_STROBE = 2'b10, EV_ERR = 2'b01;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] act;
    logic [15:0] exp;
  } probe_t;

  probe_t     pq[$];
  logic [1:0] evq[$];
  int         checks = 0;
  int         failures = 0;
  logic       probe_req = 1'b0;
  logic       probe_q = 1'b0;
  probe_t     mp;
  logic [1:0] mev;
  logic [15:0] mact;

  always @(posedge clk) probe_q <= probe_req;

  // Monitor: match pulses against the event queue, probes against the probe queue
  always @(negedge clk) begin
    if (cmd_strobe || err) begin
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL event: got strobe=%0b err=%0b, required no pulse", cmd_strobe, err);
      end else begin
        mev = evq.pop_front();
        if ({cmd_strobe, err} != mev) begin
          failures++;
          $display("FAIL event: got strobe/err=%b, required %b", {cmd_strobe, err}, mev);
        end
      end
    end
    if (probe_q && pq.size() != 0) begin
      mp = pq.pop_front();
      case (mp.kind)
        K_CHAR:  mact = {8'h00, rd_char};
        K_ADDR:  mact = {9'h000, cursor_addr};
        K_FLAGS: mact = {11'h000, two_line, display_on, cursor_on, blink_on, incr};
        K_BUSY:  mact = {15'h0000, busy};
        K_DOUT:  mact = {8'h00, data_out};
        default: mact = mp.act;
      endcase
      checks++;
      if (mact !== mp.exp) begin
        failures++;
        $display("FAIL %s: got %0h, required %0h", mp.name, mact, mp.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string nm, input int k, input logic [6:0] a,
                       input logic [15:0] act, input logic [15:0] exp);
    probe_t p;
    p.name = nm; p.kind = k; p.act = act; p.exp = exp;
    rd_addr = a;
    pq.push_back(p);
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  task automatic chk_char(input string nm, input logic [6:0] a, input logic [7:0] exp);
    probe(nm, K_CHAR, a, 16'h0000, {8'h00, exp});
  endtask

  task automatic chk_addr(input string nm, input logic [6:0] exp);
    probe(nm, K_ADDR, 7'h00, 16'h0000, {9'h000, exp});
  endtask

  task automatic bus_cmd(input logic rs_i, input logic [7:0] d, input logic [1:0] ev);
    if (ev != EV_NONE) evq.push_back(ev);
    rs = rs_i; rw = 1'b0; data_in = d; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic rs_i, input logic [1:0] ev);
    if (ev != EV_NONE) evq.push_back(ev);
    rs = rs_i; rw = 1'b1; en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    rw = 1'b0;
  endtask

  task automatic measure_busy(input string nm, input int exp);
    int n;
    n = 0;
    while (busy && n < 10000) begin
      n++;
      tick();
    end
    probe(nm, K_MEAS, 7'h00, 16'(n), 16'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10000) begin
      n++;
      tick();
    end
    if (busy) probe("idle_timeout", K_MEAS, 7'h00, 16'h0001, 16'h0000);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_char("rst_rd_char", 7'h00, 8'h00);
    chk_addr("rst_cursor", 7'h00);
    probe("rst_flags", K_FLAGS, 7'h00, 16'h0000, 16'h0001);
    probe("rst_busy", K_BUSY, 7'h00, 16'h0000, 16'h0001);
    probe("rst_data_out", K_DOUT, 7'h00, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    measure_busy("init_busy_len", 80);
    chk_char("init_00", 7'h00, CHAR_SPACE);
    chk_char("init_27", 7'h27, CHAR_SPACE);
    chk_char("init_40", 7'h40, CHAR_SPACE);
    chk_char("init_67", 7'h67, CHAR_SPACE);

    // Configuration sequence
    bus_cmd(1'b0, 8'h38, EV_STROBE);
    measure_busy("funcset_busy_len", 185);
    bus_cmd(1'b0, 8'h0E, EV_STROBE);
    wait_idle();
    bus_cmd(1'b0, 8'h01, EV_STROBE);
    measure_busy("clear_busy_len", 4000);
    bus_cmd(1'b0, 8'h02, EV_STROBE);
    measure_busy("home_busy_len", 4000);
    bus_cmd(1'b0, 8'h06, EV_STROBE);
    wait_idle();
    probe("config_flags", K_FLAGS, 7'h00, 16'h0000, 16'h001D);
    chk_addr("config_cursor", 7'h00);

    // Text writes
    bus_cmd(1'b1, 8'h4C, EV_STROBE);
    measure_busy("data_busy_len", 185);
    bus_cmd(1'b1, 8'h4F, EV_STROBE); wait_idle();
    bus_cmd(1'b1, 8'h41, EV_STROBE); wait_idle();
    bus_cmd(1'b1, 8'h44, EV_STROBE); wait_idle();
    chk_char("text_00", 7'h00, 8'h4C);
    chk_char("text_01", 7'h01, 8'h4F);
    chk_char("text_02", 7'h02, 8'h41);
    chk_char("text_03", 7'h03, 8'h44);
    chk_addr("text_cursor", 7'h04);

    // Line wrap on increment and decrement
    bus_cmd(1'b0, 8'hA7, EV_STROBE); wait_idle();
    chk_addr("setaddr_27", 7'h27);
    bus_cmd(1'b1, 8'h2B, EV_STROBE); wait_idle();
    chk_char("wrap_inc_byte", 7'h27, 8'h2B);
    chk_addr("wrap_27_to_40", 7'h40);
    bus_cmd(1'b0, 8'h80, EV_STROBE); wait_idle();
    bus_cmd(1'b0, 8'h04, EV_STROBE); wait_idle();
    bus_cmd(1'b1, 8'h2D, EV_STROBE); wait_idle();
    chk_char("wrap_dec_byte", 7'h00, 8'h2D);
    chk_char("neighbour_01", 7'h01, 8'h4F);
    chk_addr("wrap_00_to_67", 7'h67);

    // Rejections
    bus_cmd(1'b0, 8'h0C, EV_STROBE);
    bus_cmd(1'b1, 8'h41, EV_ERR);
    wait_idle();
    chk_char("busy_write_dropped", 7'h67, CHAR_SPACE);
    chk_addr("busy_write_cursor", 7'h67);
    bus_cmd(1'b0, 8'hB0, EV_ERR);
    probe("bad_addr_not_busy", K_BUSY, 7'h00, 16'h0000, 16'h0000);
    chk_addr("bad_addr_cursor", 7'h67);
    bus_cmd(1'b0, 8'h40, EV_ERR);
    probe("cgram_not_busy", K_BUSY, 7'h00, 16'h0000, 16'h0000);

    // Remaining wraps, shifts and invalid renderer reads
    bus_cmd(1'b0, 8'h06, EV_STROBE); wait_idle();
    bus_cmd(1'b1, 8'h5A, EV_STROBE); wait_idle();
    chk_addr("wrap_67_to_00", 7'h00);
    chk_char("line2_last_byte", 7'h67, 8'h5A);
    bus_cmd(1'b0, 8'hC0, EV_STROBE); wait_idle();
    bus_cmd(1'b0, 8'h10, EV_STROBE); wait_idle();
    chk_addr("shift_40_to_27", 7'h27);
    bus_cmd(1'b0, 8'h1C, EV_STROBE); wait_idle();
    chk_addr("display_shift_no_move", 7'h27);
    chk_char("invalid_30", 7'h30, 8'h00);
    chk_char("invalid_68", 7'h68, 8'h00);

`ifdef LCD_RESP_READ_EN
    bus_read(1'b1, EV_STROBE);
    probe("read_data", K_DOUT, 7'h00, 16'h0000, 16'h002B);
    wait_idle();
    chk_addr("read_steps_cursor", 7'h40);
`else
    bus_read(1'b1, EV_NONE);
    chk_addr("read_ignored_cursor", 7'h27);
    probe("read_ignored_busy", K_BUSY, 7'h00, 16'h0000, 16'h0000);
    probe("read_data_out_zero", K_DOUT, 7'h00, 16'h0000, 16'h0000);
`endif

    // Second clear restores blanks and incr
    bus_cmd(1'b0, 8'h04, EV_STROBE); wait_idle();
    bus_cmd(1'b0, 8'h01, EV_STROBE);
`ifdef LCD_RESP_READ_EN
    bus_read(1'b0, EV_NONE);
    probe("status_during_clear", K_DOUT, 7'h00, 16'h0000, 16'h0080);
`endif
    wait_idle();
`ifdef LCD_RESP_READ_EN
    bus_read(1'b0, EV_NONE);
    probe("status_after_clear", K_DOUT, 7'h00, 16'h0000, 16'h0000);
`endif
    probe("clear_flags", K_FLAGS, 7'h00, 16'h0000, 16'h0019);
    chk_addr("clear_cursor", 7'h00);
    chk_char("clear_00", 7'h00, CHAR_SPACE);
    chk_char("clear_27", 7'h27, CHAR_SPACE);
    chk_char("clear_67", 7'h67, CHAR_SPACE);

    repeat (5) tick();
    probe("events_drained", K_MEAS, 7'h00, 16'(evq.size()), 16'h0000);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Responder end of the HD44780-style parallel bus driven by the team's `lcd` writer. It decodes EN/RS/RW/data transactions, maintains an 80-byte DDRAM, cursor address and display-control state, and models the busy time of each instruction. It serves as a bus-functional target in simulation and as a synthesizable text buffer whose contents a downstream renderer reads through `rd_addr`/`rd_char`.

## Interface
- `CMD_CYCLES`, default 185: busy duration of ordinary instructions and data writes.
- `CLEAR_CYCLES`, default 4000: busy duration of clear and home. Must be ≥ 80.
- `clk` input, 1 bit: the single clock. All bus inputs are synchronous to it.
- `rst_n` input, 1 bit: reset. Asynchronous, active-low.
- `en`, `rs`, `rw` inputs, 1 bit each: bus strobe, register select (1 = data), and read/write (1 = read).
- `data_in` input, 8 bits: bus data from the writer.
- `data_out` output, 8 bits: read data, valid only with `LCD_RESP_READ_EN`.
- `busy` output, 1 bit: an instruction is executing.
- `cursor_addr` output, 7 bits: DDRAM address counter.
- `display_on`, `cursor_on`, `blink_on` outputs, 1 bit each: display-control flags.
- `incr`, `two_line` outputs, 1 bit each: entry I/D flag and function-set N flag.
- `rd_addr` input, 7 bits: renderer read address, in DDRAM encoding.
- `rd_char` output, 8 bits: registered DDRAM byte at `rd_addr`.
- `cmd_strobe` output, 1 bit: one-cycle pulse per accepted transaction.
- `err` output, 1 bit: one-cycle pulse per rejected transaction.

## Operation
**Transaction capture**
- While `en`=1, `rs`/`rw`/`data_in` are registered every cycle.
- A transaction commits on the falling edge of `en`, detected as `en_q`=1, `en`=0. The values used are the last ones registered while `en` was high.

**DDRAM map**
- Line 1 occupies 0x00–0x27 (index 0–39). Line 2 occupies 0x40–0x67 (index 40–79).
- Increment wraps 0x27→0x40 and 0x67→0x00.
- Decrement wraps 0x00→0x67 and 0x40→0x27.

**Write decode (`rw`=0), accepted only when not busy**
- `rs`=1: write `ddram[cursor_addr]` = data, then step the address per `incr`. Busy for `CMD_CYCLES`.
- 0x01 clear: address = 0, `incr`=1, all 80 bytes filled with 0x20 one per cycle. Busy for `CLEAR_CYCLES`.
- 0x02–0x03 home: address = 0. Busy for `CLEAR_CYCLES`.
- 0x04–0x07 entry mode: `incr` = bit1. Bit0 (display shift) is ignored.
- 0x08–0x0F display control: `display_on` = bit2, `cursor_on` = bit1, `blink_on` = bit0.
- 0x10–0x1F shift: if bit3=0, step the cursor (bit2=1 → increment, else decrement). If bit3=1 (display shift), no state change.
- 0x20–0x3F function set: `two_line` = bit3.
- 0x40–0x7F CGRAM address: unsupported. Pulse `err`, no state change.
- 0x80–0xFF set address: take bits[6:0]. Values 0x28–0x3F and 0x68–0x7F pulse `err` and are ignored.
- Every accepted instruction not listed with its own duration is busy for `CMD_CYCLES`.

**Rejections and pulses**
- A commit while busy pulses `err`. DDRAM and all flags are unchanged.
- `cmd_strobe` pulses on every accepted commit.
- Read transactions (`rw`=1) affect nothing without the macro. They pulse neither `cmd_strobe` nor `err`.

**State machine**
- States: INIT_FILL, IDLE, EXEC, CLEAR_FILL.
- INIT_FILL → IDLE after 80 fill cycles.
- IDLE → EXEC on an accepted instruction or data write.
- IDLE → CLEAR_FILL on 0x01.
- CLEAR_FILL → EXEC after 80 fill cycles; the busy counter continues to `CLEAR_CYCLES`.
- EXEC → IDLE when the counter expires.

**Reset values**
- State INIT_FILL, `busy`=1, `cursor_addr`=0.
- `display_on`=`cursor_on`=`blink_on`=0, `incr`=1, `two_line`=0.
- `data_out`=0, `rd_char`=0, `cmd_strobe`=`err`=0.
- DDRAM is filled with 0x20 during INIT_FILL.
- Reset asserted mid-operation aborts everything and restarts INIT_FILL.

## Timing
- Commit happens at the clock edge that samples `en`=0 after `en`=1. `busy`, `cmd_strobe` and the flags update at that edge.
- The DDRAM write lands at that edge. The address step is visible the following cycle.
- `busy` stays high for exactly N cycles after commit, with N = `CMD_CYCLES` or `CLEAR_CYCLES`. A commit on the cycle `busy` falls is accepted.
- `rd_char` has 1-cycle latency from `rd_addr`. Invalid addresses return 0x00. During a fill, `rd_char` returns the in-progress contents.
- A fill write and a renderer read of the same index in the same cycle return the old data.

## Configuration
- With `LCD_RESP_READ_EN` defined:
  - While `en`=1 and `rw`=1, `data_out` is registered each cycle.
  - `rs`=0 gives `{busy, cursor_addr}`. This read is permitted during busy.
  - `rs`=1 gives `ddram[cursor_addr]`, and its `en` falling edge steps the address. When not busy this counts as an accepted commit and sets busy for `CMD_CYCLES`. When busy it pulses `err`.
- Without the macro: `data_out` is tied to 0 and all `rw`=1 transactions are ignored.

## Structure
- Package `lcd_pkg` holds:
  - instruction-class constants (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, CGRAM, DDRAM) and the data/command encodings;
  - the state enum;
  - line base addresses (0x00, 0x40) and the line length (40);
  - address-to-index and next/previous-address helper functions.
- One sub-module, `lcd_ddram`: 80×8 memory with one write port and two registered read ports (renderer and bus read).

## Test plan
1. Release `rst_n` → `busy`=1 for 80 cycles. Afterwards `rd_addr` 0x00, 0x27, 0x40, 0x67 each give `rd_char`=0x20.
2. Send 0x38, 0x0E, 0x01, 0x02, 0x06, each waiting out `busy` → `two_line`=1, `display_on`=1, `cursor_on`=1, `blink_on`=0, `incr`=1, `cursor_addr`=0x00. 0x01 holds `busy` for 4000 cycles.
3. Data writes 0x4C, 0x4F, 0x41, 0x44 → `rd_char` at 0x00–0x03 = 4C 4F 41 44, `cursor_addr`=0x04.
4. Send 0xA7 then write 0x2B → byte at 0x27 = 0x2B and `cursor_addr`=0x40. Send 0x80, 0x04, then write 0x2D → byte at 0x00 = 0x2D and `cursor_addr`=0x67.
5. Pulse `en` with 0x41 while `busy` → `err` is high for one cycle and byte at `cursor_addr` is unchanged. Send 0xB0 → `err` pulses and `cursor_addr` is unchanged.
6. With `LCD_RESP_READ_EN`, set `rw`=1, `rs`=0 during a clear → `data_out[7]`=1. After the clear completes → `data_out`=0x00.
